sync_filter: RTL and testbench

Multi-channel, parametrised successor to the single-bit synchroniser. Each of `WIDTH` asynchronous level inputs passes through a `STAGES`-deep synchroniser chain, then a per-channel glitch filter with a stable-count threshold. The block emits registered rising/falling edge strobes and a global change strobe. It sits at the boundary where PHY status pins, link/lock indicators and user straps enter the `clk` domain.

---
 rtl/sync_filter_ch.sv | 86 ++++++++
 rtl/sync_filter.sv | 50 +++++
 tb/tb_sync_filter.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_filter_ch.sv
// Single-channel synchroniser chain, stable-count glitch filter and
// registered rise/fall strobe generation.
module sync_filter_ch #(
    parameter int STAGES        = 2,
    parameter int FILTER_CYCLES = 1,
    parameter int INIT          = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic flip_next
);

    localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam logic INIT_BIT = (INIT != 0);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_filter_ch: STAGES must be at least 2");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("sync_filter_ch: FILTER_CYCLES must be at least 1");
    end
    if (INIT != 0 && INIT != 1) begin : g_bad_init
        $error("sync_filter_ch: INIT must be 0 or 1");
    end

    // Chain flops must stay distinct physical flops so the metastability
    // settling time is not eaten by retiming or shift-register packing.
    (* keep = "true" *) logic [STAGES-1:0] chain;

    logic             s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             out_next;

    assign s         = chain[STAGES-1];
    assign flip_next = (out_next != out);

    // Synchroniser shift register, stage 0 samples the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the chain is a handful of flops, not a memory, so it is reset
        //       to INIT; this keeps reset release from producing a strobe.
        if (!rst_n) begin
            chain <= {STAGES{INIT_BIT}};
        end else begin
            // NOTE: non-blocking assignment so every stage sees the previous
            //       value of its neighbour within the same edge.
            chain <= {chain[STAGES-2:0], in};
        end
    end

    // Filter decision: a differing level must survive FILTER_CYCLES edges.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        //       latch is inferred.
        cnt_next = '0;
        out_next = out;
        if (s != out) begin
            if (cnt == CNT_LAST) begin
                out_next = s;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    // Filtered level, stable counter and strobes coincident with the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out  <= INIT_BIT;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            out  <= out_next;
            cnt  <= cnt_next;
            rise <= out_next & ~out;
            fall <= ~out_next & out;
        end
    end

endmodule

// File: rtl/sync_filter.sv
// Multi-channel synchroniser with per-channel glitch filter, edge strobes
// and a global change strobe.
module sync_filter #(
    parameter int WIDTH         = 1,
    parameter int STAGES        = 2,
    parameter int FILTER_CYCLES = 1,
    parameter int INIT          = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_filter: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] flip_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sync_filter_ch #(
            .STAGES        (STAGES),
            .FILTER_CYCLES (FILTER_CYCLES),
            .INIT          (INIT)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .in        (in[i]),
            .out       (out[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .flip_next (flip_next[i])
        );
    end

    // Global strobe registered from the channels' next-edge flips so it
    // lines up with the per-channel rise/fall registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed <= 1'b0;
        end else begin
            changed <= |flip_next;
        end
    end

endmodule

// File: tb/tb_sync_filter.sv
// Self-checking bench for sync_filter: five parameterisations share clk and
// rst_n, a history-window reference model is checked every cycle, and each
// scenario task adds its own directed comparisons.
module tb_sync_filter;

    localparam int N_INST = 5;
    // Instance table: a = WIDTH 4, b = FILTER 4, c = STAGES 3/FILTER 3/INIT 1,
    // d = FILTER 2, e = all defaults.
    localparam int ST  [N_INST] = '{2, 2, 3, 2, 2};
    localparam int FC  [N_INST] = '{1, 4, 3, 2, 1};
    localparam int WD  [N_INST] = '{4, 1, 2, 1, 1};
    localparam bit INI [N_INST] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [3:0] in_a = '0, out_a, rise_a, fall_a;
    logic       chg_a;
    logic       in_b = 1'b0, out_b, rise_b, fall_b, chg_b;
    logic [1:0] in_c = '0, out_c, rise_c, fall_c;
    logic       chg_c;
    logic       in_d = 1'b0, out_d, rise_d, fall_d, chg_d;
    logic       in_e = 1'b0, out_e, rise_e, fall_e, chg_e;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    sync_filter #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(1), .INIT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in(in_a), .out(out_a), .rise(rise_a), .fall(fall_a), .changed(chg_a));
    sync_filter #(.WIDTH(1), .STAGES(2), .FILTER_CYCLES(4), .INIT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in(in_b), .out(out_b), .rise(rise_b), .fall(fall_b), .changed(chg_b));
    sync_filter #(.WIDTH(2), .STAGES(3), .FILTER_CYCLES(3), .INIT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in(in_c), .out(out_c), .rise(rise_c), .fall(fall_c), .changed(chg_c));
    sync_filter #(.WIDTH(1), .STAGES(2), .FILTER_CYCLES(2), .INIT(0)) u_d (
        .clk(clk), .rst_n(rst_n), .in(in_d), .out(out_d), .rise(rise_d), .fall(fall_d), .changed(chg_d));
    sync_filter u_e (
        .clk(clk), .rst_n(rst_n), .in(in_e), .out(out_e), .rise(rise_e), .fall(fall_e), .changed(chg_e));

    // Uniform views of every instance, zero-extended to 4 channels.
    logic [3:0] cur_in   [N_INST];
    logic [3:0] act_out  [N_INST];
    logic [3:0] act_rise [N_INST];
    logic [3:0] act_fall [N_INST];
    logic       act_chg  [N_INST];

    always_comb begin
        cur_in[0] = in_a;           cur_in[1] = {3'b0, in_b};   cur_in[2] = {2'b0, in_c};
        cur_in[3] = {3'b0, in_d};   cur_in[4] = {3'b0, in_e};
        act_out[0] = out_a;         act_out[1] = {3'b0, out_b}; act_out[2] = {2'b0, out_c};
        act_out[3] = {3'b0, out_d}; act_out[4] = {3'b0, out_e};
        act_rise[0] = rise_a;         act_rise[1] = {3'b0, rise_b}; act_rise[2] = {2'b0, rise_c};
        act_rise[3] = {3'b0, rise_d}; act_rise[4] = {3'b0, rise_e};
        act_fall[0] = fall_a;         act_fall[1] = {3'b0, fall_b}; act_fall[2] = {2'b0, fall_c};
        act_fall[3] = {3'b0, fall_d}; act_fall[4] = {3'b0, fall_e};
        act_chg[0] = chg_a; act_chg[1] = chg_b; act_chg[2] = chg_c;
        act_chg[3] = chg_d; act_chg[4] = chg_e;
    end

    // ------------------------------------------------------------------
    // Reference model: keeps the history of sampled inputs since reset.
    // The level seen by the filter at edge e is the input sampled STAGES
    // edges earlier (INIT before that); out flips when the last
    // FILTER_CYCLES filter levels all differ from out.
    // ------------------------------------------------------------------
    bit m_out  [N_INST][4];
    bit m_rise [N_INST][4];
    bit m_fall [N_INST][4];
    bit m_chg  [N_INST];
    bit hin    [N_INST][4][64];
    bit hs     [N_INST][4][64];
    int ecnt   [N_INST];
    int m_e;
    bit m_sp, m_flip, m_hv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_INST; i++) begin
                ecnt[i]  = 0;
                m_chg[i] = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    m_out[i][c]  = (c < WD[i]) ? INI[i] : 1'b0;
                    m_rise[i][c] = 1'b0;
                    m_fall[i][c] = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < N_INST; i++) begin
                m_chg[i] = 1'b0;
                m_e = ecnt[i];
                for (int c = 0; c < WD[i]; c++) begin
                    m_sp = (m_e >= ST[i]) ? hin[i][c][(m_e - ST[i]) % 64] : INI[i];
                    hs[i][c][m_e % 64]  = m_sp;
                    hin[i][c][m_e % 64] = cur_in[i][c];
                    m_flip = 1'b1;
                    for (int j = 0; j < FC[i]; j++) begin
                        m_hv = (m_e - j < 0) ? INI[i] : hs[i][c][(m_e - j) % 64];
                        if (m_hv == m_out[i][c]) m_flip = 1'b0;
                    end
                    m_rise[i][c] = m_flip && !m_out[i][c];
                    m_fall[i][c] = m_flip && m_out[i][c];
                    if (m_flip) m_out[i][c] = !m_out[i][c];
                    m_chg[i] = m_chg[i] | m_flip;
                end
                ecnt[i] = ecnt[i] + 1;
            end
        end
    end

    // Scoreboard: every instance against the model, away from the active edge.
    logic [3:0] ev_out, ev_rise, ev_fall;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            for (int i = 0; i < N_INST; i++) begin
                for (int c = 0; c < 4; c++) begin
                    ev_out[c]  = m_out[i][c];
                    ev_rise[c] = m_rise[i][c];
                    ev_fall[c] = m_fall[i][c];
                end
                total += 4;
                if (act_out[i] !== ev_out) begin
                    bad++;
                    $display("FAIL model_out inst=%0d t=%0t got=%b want=%b", i, $time, act_out[i], ev_out);
                end
                if (act_rise[i] !== ev_rise) begin
                    bad++;
                    $display("FAIL model_rise inst=%0d t=%0t got=%b want=%b", i, $time, act_rise[i], ev_rise);
                end
                if (act_fall[i] !== ev_fall) begin
                    bad++;
                    $display("FAIL model_fall inst=%0d t=%0t got=%b want=%b", i, $time, act_fall[i], ev_fall);
                end
                if (act_chg[i] !== m_chg[i]) begin
                    bad++;
                    $display("FAIL model_changed inst=%0d t=%0t got=%b want=%b", i, $time, act_chg[i], m_chg[i]);
                end
            end
        end
    end

    // One active edge, then settle past it.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Asserts reset mid-cycle and checks the outputs without waiting for a clock.
    task automatic check_reset_values(input string tag);
        total++;
        if ({out_a, rise_a, fall_a, chg_a} !== 13'b0 ||
            {out_b, rise_b, fall_b, chg_b} !== 4'b0 ||
            {out_c, rise_c, fall_c, chg_c} !== 7'b11_00_00_0 ||
            {out_d, rise_d, fall_d, chg_d} !== 4'b0 ||
            {out_e, rise_e, fall_e, chg_e} !== 4'b0) begin
            bad++;
            $display("FAIL %s got a=%b/%b/%b/%b c=%b/%b/%b/%b b=%b d=%b e=%b want a=0 b=0 c=out 11 strobes 0 d=0 e=0",
                     tag, out_a, rise_a, fall_a, chg_a, out_c, rise_c, fall_c, chg_c,
                     {out_b, rise_b, fall_b, chg_b}, {out_d, rise_d, fall_d, chg_d},
                     {out_e, rise_e, fall_e, chg_e});
        end
    endtask

    // Reset without a clock, then INIT=1 channel falls STAGES+FILTER edges after release.
    task automatic test_reset;
        logic [6:0] exp_c;
        in_a = '0; in_b = 1'b0; in_c = 2'b00; in_d = 1'b0; in_e = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset_async_no_clock");
        tick(3);
        check_reset_values("reset_held");
        @(negedge clk);
        #2 rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 6)       exp_c = {2'b11, 2'b00, 2'b00, 1'b0};
            else if (k == 6) exp_c = {2'b00, 2'b00, 2'b11, 1'b1};
            else             exp_c = {2'b00, 2'b00, 2'b00, 1'b0};
            total++;
            if ({out_c, rise_c, fall_c, chg_c} !== exp_c) begin
                bad++;
                $display("FAIL release_init1 edge=%0d got=%b want=%b", k, {out_c, rise_c, fall_c, chg_c}, exp_c);
            end
        end
    endtask

    // Default parameters: rising input seen on out three edges later, one-cycle strobe.
    task automatic test_default_rise;
        logic [3:0] exp_e;
        in_e = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_e = {k >= 3, k == 3, 1'b0, k == 3};
            total++;
            if ({out_e, rise_e, fall_e, chg_e} !== exp_e) begin
                bad++;
                $display("FAIL default_rise edge=%0d got=%b want=%b", k, {out_e, rise_e, fall_e, chg_e}, exp_e);
            end
        end
        in_e = 1'b0;
        tick(5);
    endtask

    // FILTER_CYCLES=4: a 3-cycle glitch is rejected, a 4-cycle pulse passes intact.
    task automatic test_glitch_f4;
        logic [3:0] exp_b;
        in_b = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            total++;
            if ({out_b, rise_b, fall_b, chg_b} !== 4'b0000) begin
                bad++;
                $display("FAIL glitch3_rejected edge=%0d got=%b want=0000", k, {out_b, rise_b, fall_b, chg_b});
            end
            if (k == 3) in_b = 1'b0;
        end
        in_b = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_b = {k >= 6 && k <= 9, k == 6, k == 10, k == 6 || k == 10};
            total++;
            if ({out_b, rise_b, fall_b, chg_b} !== exp_b) begin
                bad++;
                $display("FAIL pulse4_passed edge=%0d got=%b want=%b", k, {out_b, rise_b, fall_b, chg_b}, exp_b);
            end
            if (k == 4) in_b = 1'b0;
        end
    endtask

    // WIDTH=4: simultaneous channel changes, one shared changed pulse.
    task automatic test_width4;
        logic [12:0] exp_a;
        in_a = 4'b0101;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_a = {(k >= 3) ? 4'b0101 : 4'b0000, (k == 3) ? 4'b0101 : 4'b0000, 4'b0000, k == 3};
            total++;
            if ({out_a, rise_a, fall_a, chg_a} !== exp_a) begin
                bad++;
                $display("FAIL width4_rise edge=%0d got=%b want=%b", k, {out_a, rise_a, fall_a, chg_a}, exp_a);
            end
        end
        in_a = 4'b0011;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_a = {(k >= 3) ? 4'b0011 : 4'b0101, (k == 3) ? 4'b0010 : 4'b0000,
                     (k == 3) ? 4'b0100 : 4'b0000, k == 3};
            total++;
            if ({out_a, rise_a, fall_a, chg_a} !== exp_a) begin
                bad++;
                $display("FAIL width4_mixed edge=%0d got=%b want=%b", k, {out_a, rise_a, fall_a, chg_a}, exp_a);
            end
        end
    endtask

    // Reset while filters are counting: the pending count is discarded.
    task automatic test_reset_mid_filter;
        logic [6:0] exp_c;
        logic [3:0] exp_b;
        in_c = 2'b11;
        in_b = 1'b1;
        tick(5);
        total++;
        if ({out_c, out_b} !== 3'b000) begin
            bad++;
            $display("FAIL pending_before_reset got=%b want=000", {out_c, out_b});
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset_mid_filter");
        tick(2);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_c = {2'b11, 2'b00, 2'b00, 1'b0};
            exp_b = {k >= 6, k == 6, 1'b0, k == 6};
            total++;
            if ({out_c, rise_c, fall_c, chg_c} !== exp_c) begin
                bad++;
                $display("FAIL no_pulse_after_release edge=%0d got=%b want=%b", k, {out_c, rise_c, fall_c, chg_c}, exp_c);
            end
            total++;
            if ({out_b, rise_b, fall_b, chg_b} !== exp_b) begin
                bad++;
                $display("FAIL count_restarts edge=%0d got=%b want=%b", k, {out_b, rise_b, fall_b, chg_b}, exp_b);
            end
        end
        in_b = 1'b0;
        tick(8);
    endtask

    // FILTER_CYCLES=2 with the input toggling every cycle: nothing passes.
    task automatic test_toggle;
        for (int k = 1; k <= 50; k++) begin
            in_d = ~in_d;
            tick();
            total++;
            if ({out_d, rise_d, fall_d, chg_d} !== 4'b0000) begin
                bad++;
                $display("FAIL toggle_blocked cycle=%0d got=%b want=0000", k, {out_d, rise_d, fall_d, chg_d});
            end
        end
        in_d = 1'b0;
        tick(4);
    endtask

    // Random levels with random hold times on every instance, plus one
    // reset in the middle; the scoreboard does the comparing.
    task automatic test_random;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(3, 0) == 0) in_a = 4'($urandom);
            if ($urandom_range(2, 0) == 0) in_b = 1'($urandom);
            if ($urandom_range(3, 0) == 0) in_c = 2'($urandom);
            if ($urandom_range(1, 0) == 0) in_d = 1'($urandom);
            if ($urandom_range(4, 0) == 0) in_e = 1'($urandom);
            if (k == 300) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1 check_reset_values("reset_random_mid");
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "bench timed out");
    end

    initial begin
        test_reset();
        test_default_rise();
        test_glitch_f4();
        test_width4();
        test_reset_mid_filter();
        test_toggle();
        test_random();
        tick(2);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
